rr_grant_sequencer: RTL and testbench



---
 rtl/rr_grant_sequencer.sv | 149 ++++++++++++++
 tb/tb_rr_grant_sequencer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/rr_grant_sequencer.sv
// Round-robin grant sequencer: one-cycle grant pulses separated by a cool-down cycle,
// cancel/go suspension, and per-requester wait-age tracking with sticky deadline-miss flags.
module rr_grant_sequencer #(
   parameter int N        = 4,
   parameter int DEADLINE = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [N-1:0] req,
   input  logic         cancel,
   input  logic         go,
   output logic [N-1:0] grant,
   output logic         holding,
   output logic [N-1:0] miss
);

   localparam int PW = (N > 1) ? $clog2(N) : 1;
   localparam int AW = $clog2(DEADLINE + 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_GRANT = 2'd1,
      S_COOL  = 2'd2,
      S_HOLD  = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [N-1:0]    pend_q, pend_d;
   logic [PW-1:0]   ptr_q, ptr_d;
   logic [PW-1:0]   sel_q, sel_d;
   logic [N-1:0]    cand;
   logic [PW-1:0]   pick;
   logic            enter_grant;

   // Rotating priority search: first candidate at or above ptr, wrapping at N-1.
   always_comb begin
      int  j;
      logic found;
      pick  = '0;
      found = 1'b0;
      cand  = pend_q | req;
      for (int k = 0; k < N; k++) begin
         j = int'(ptr_q) + k;
         if (j >= N) begin
            j = j - N;
         end
         if (!found && cand[j]) begin
            found = 1'b1;
            pick  = PW'(j);
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      enter_grant = 1'b0;
      case (state_q)
         S_IDLE, S_COOL: begin
            if (cancel) begin
               state_d = S_HOLD;
            end else if (|cand) begin
               state_d     = S_GRANT;
               enter_grant = 1'b1;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_GRANT: begin
            state_d = cancel ? S_HOLD : S_COOL;
         end
         S_HOLD: begin
            if (go && !cancel) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // A request picked on the same edge it arrives is consumed without ever pending.
   always_comb begin
      pend_d = cand;
      sel_d  = sel_q;
      ptr_d  = ptr_q;
      if (enter_grant) begin
         pend_d[pick] = 1'b0;
         sel_d        = pick;
         ptr_d        = (pick == PW'(N - 1)) ? '0 : pick + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         pend_q  <= '0;
         ptr_q   <= '0;
         sel_q   <= '0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         ptr_q   <= ptr_d;
         sel_q   <= sel_d;
      end
   end

   always_comb begin
      grant = '0;
      if (state_q == S_GRANT) begin
         grant[sel_q] = 1'b1;
      end
   end

   assign holding = (state_q == S_HOLD);

   // Ages freeze while suspended; a saturated age keeps re-flagging the sticky miss.
   generate
      for (genvar gi = 0; gi < N; gi++) begin : g_age
         logic [AW-1:0] age_q, age_d;
         logic          miss_q, miss_d;

         always_comb begin
            age_d  = age_q;
            miss_d = miss_q;
            if (!pend_q[gi] || !pend_d[gi]) begin
               age_d = '0;
            end else if (state_q == S_HOLD) begin
               age_d = age_q;
            end else if (age_q == AW'(DEADLINE)) begin
               miss_d = 1'b1;
            end else begin
               age_d = age_q + 1'b1;
            end
         end

         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               age_q  <= '0;
               miss_q <= 1'b0;
            end else begin
               age_q  <= age_d;
               miss_q <= miss_d;
            end
         end

         assign miss[gi] = miss_q;
      end
   endgenerate

endmodule

// File: tb/tb_rr_grant_sequencer.sv
// Directed table-driven bench for rr_grant_sequencer; two instances (DEADLINE 8 and 2)
// share stimulus so arbitration and deadline-miss behaviour are checked side by side.
module tb_rr_grant_sequencer;

   logic       clk;
   logic       reset;
   logic [3:0] req;
   logic       cancel;
   logic       go;
   logic [3:0] grant8, grant2;
   logic       hold8, hold2;
   logic [3:0] miss8, miss2;

   int n_cmp;
   int n_err;

   rr_grant_sequencer #(.N(4), .DEADLINE(8)) dut8 (
      .clk     (clk),
      .reset   (reset),
      .req     (req),
      .cancel  (cancel),
      .go      (go),
      .grant   (grant8),
      .holding (hold8),
      .miss    (miss8)
   );

   rr_grant_sequencer #(.N(4), .DEADLINE(2)) dut2 (
      .clk     (clk),
      .reset   (reset),
      .req     (req),
      .cancel  (cancel),
      .go      (go),
      .grant   (grant2),
      .holding (hold2),
      .miss    (miss2)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       rst_before;
      logic [3:0] req;
      logic       cancel;
      logic       go;
      logic [3:0] exp_grant;
      logic       exp_hold;
      logic [3:0] exp_miss8;
      logic [3:0] exp_miss2;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(input logic rb, input logic [3:0] r, input logic c, input logic g,
                               input logic [3:0] eg, input logic eh, input logic [3:0] em8,
                               input logic [3:0] em2);
      vec_t v;
      v.rst_before = rb;
      v.req        = r;
      v.cancel     = c;
      v.go         = g;
      v.exp_grant  = eg;
      v.exp_hold   = eh;
      v.exp_miss8  = em8;
      v.exp_miss2  = em2;
      vecs.push_back(v);
   endfunction

   task automatic chk4(input string name, input logic [3:0] act, input logic [3:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %b, expected %b", name, act, exp);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %b, expected %b", name, act, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic [3:0] eg, input logic eh,
                            input logic [3:0] em8, input logic [3:0] em2);
      chk4({tag, " grant8"}, grant8, eg);
      chk4({tag, " grant2"}, grant2, eg);
      chk1({tag, " holding8"}, hold8, eh);
      chk1({tag, " holding2"}, hold2, eh);
      chk4({tag, " miss8"}, miss8, em8);
      chk4({tag, " miss2"}, miss2, em2);
   endtask

   task automatic do_reset();
      reset  = 1'b1;
      req    = '0;
      cancel = 1'b0;
      go     = 1'b0;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      check_all("reset", 4'b0000, 1'b0, 4'b0000, 4'b0000);
      $display("reset: grant=%b holding=%b miss8=%b miss2=%b", grant8, hold8, miss8, miss2);
   endtask

   task automatic step(input logic [3:0] r);
      req = r;
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      clk    = 1'b0;
      reset  = 1'b0;
      req    = '0;
      cancel = 1'b0;
      go     = 1'b0;
      n_cmp  = 0;
      n_err  = 0;

      // single request, then return to idle with nothing pending
      add(1, 4'b0100, 0, 0, 4'b0100, 0, 4'b0000, 4'b0000);
      add(0, 4'b0000, 0, 0, 4'b0000, 0, 4'b0000, 4'b0000);
      add(0, 4'b0000, 0, 0, 4'b0000, 0, 4'b0000, 4'b0000);
      add(0, 4'b0000, 0, 0, 4'b0000, 0, 4'b0000, 4'b0000);
      // all four request: round-robin every 2 cycles; DEADLINE=2 misses 2 and 3
      add(1, 4'b1111, 0, 0, 4'b0001, 0, 4'b0000, 4'b0000);
      add(0, 4'b0000, 0, 0, 4'b0000, 0, 4'b0000, 4'b0000);
      add(0, 4'b0000, 0, 0, 4'b0010, 0, 4'b0000, 4'b0000);
      add(0, 4'b0000, 0, 0, 4'b0000, 0, 4'b0000, 4'b1100);
      add(0, 4'b0000, 0, 0, 4'b0100, 0, 4'b0000, 4'b1100);
      add(0, 4'b0000, 0, 0, 4'b0000, 0, 4'b0000, 4'b1100);
      add(0, 4'b0000, 0, 0, 4'b1000, 0, 4'b0000, 4'b1100);
      add(0, 4'b0000, 0, 0, 4'b0000, 0, 4'b0000, 4'b1100);
      add(0, 4'b0000, 0, 0, 4'b0000, 0, 4'b0000, 4'b1100);
      // cancel during grant; cancel+go keeps HOLD with ages frozen
      add(1, 4'b0011, 0, 0, 4'b0001, 0, 4'b0000, 4'b0000);
      add(0, 4'b0000, 1, 0, 4'b0000, 1, 4'b0000, 4'b0000);
      add(0, 4'b0000, 1, 1, 4'b0000, 1, 4'b0000, 4'b0000);
      add(0, 4'b0000, 0, 0, 4'b0000, 1, 4'b0000, 4'b0000);
      add(0, 4'b0000, 1, 1, 4'b0000, 1, 4'b0000, 4'b0000);
      add(0, 4'b0000, 0, 1, 4'b0000, 0, 4'b0000, 4'b0000);
      add(0, 4'b0000, 0, 0, 4'b0010, 0, 4'b0000, 4'b0000);
      add(0, 4'b0000, 0, 0, 4'b0000, 0, 4'b0000, 4'b0000);
      add(0, 4'b0000, 0, 0, 4'b0000, 0, 4'b0000, 4'b0000);
      // re-request of the granted requester during GRANT re-pends it; cancel from IDLE
      add(1, 4'b0001, 0, 0, 4'b0001, 0, 4'b0000, 4'b0000);
      add(0, 4'b0001, 0, 0, 4'b0000, 0, 4'b0000, 4'b0000);
      add(0, 4'b0000, 0, 0, 4'b0001, 0, 4'b0000, 4'b0000);
      add(0, 4'b0000, 0, 0, 4'b0000, 0, 4'b0000, 4'b0000);
      add(0, 4'b0000, 0, 0, 4'b0000, 0, 4'b0000, 4'b0000);
      add(0, 4'b0000, 1, 0, 4'b0000, 1, 4'b0000, 4'b0000);
      add(0, 4'b0000, 0, 1, 4'b0000, 0, 4'b0000, 4'b0000);
      // pointer wrap: after granting 1, ptr=2, so 0 wins over 1
      add(1, 4'b0010, 0, 0, 4'b0010, 0, 4'b0000, 4'b0000);
      add(0, 4'b0000, 0, 0, 4'b0000, 0, 4'b0000, 4'b0000);
      add(0, 4'b0000, 0, 0, 4'b0000, 0, 4'b0000, 4'b0000);
      add(0, 4'b0011, 0, 0, 4'b0001, 0, 4'b0000, 4'b0000);
      add(0, 4'b0000, 0, 0, 4'b0000, 0, 4'b0000, 4'b0000);
      add(0, 4'b0000, 0, 0, 4'b0010, 0, 4'b0000, 4'b0000);
      add(0, 4'b0000, 0, 0, 4'b0000, 0, 4'b0000, 4'b0000);
      // lead-in for async reset: end with grant=0010, pend=0100, miss2=1110
      add(1, 4'b1111, 0, 0, 4'b0001, 0, 4'b0000, 4'b0000);
      add(0, 4'b0000, 0, 0, 4'b0000, 0, 4'b0000, 4'b0000);
      add(0, 4'b0000, 0, 0, 4'b0010, 0, 4'b0000, 4'b0000);
      add(0, 4'b0000, 0, 0, 4'b0000, 0, 4'b0000, 4'b1100);
      add(0, 4'b0010, 0, 0, 4'b0100, 0, 4'b0000, 4'b1100);
      add(0, 4'b0000, 0, 0, 4'b0000, 0, 4'b0000, 4'b1100);
      add(0, 4'b0000, 0, 0, 4'b1000, 0, 4'b0000, 4'b1100);
      add(0, 4'b0000, 0, 0, 4'b0000, 0, 4'b0000, 4'b1110);
      add(0, 4'b0100, 0, 0, 4'b0010, 0, 4'b0000, 4'b1110);

      @(negedge clk);
      for (int i = 0; i < vecs.size(); i++) begin
         if (vecs[i].rst_before) begin
            do_reset();
         end
         cancel = vecs[i].cancel;
         go     = vecs[i].go;
         step(vecs[i].req);
         check_all($sformatf("vec%0d", i), vecs[i].exp_grant, vecs[i].exp_hold,
                   vecs[i].exp_miss8, vecs[i].exp_miss2);
         $display("vec %0d: req=%b cancel=%b go=%b -> grant=%b holding=%b miss8=%b miss2=%b",
                  i, vecs[i].req, vecs[i].cancel, vecs[i].go, grant8, hold8, miss8, miss2);
      end

      // asynchronous reset mid-grant: outputs clear before the next edge
      req    = '0;
      cancel = 1'b0;
      go     = 1'b0;
      #2;
      reset = 1'b1;
      #1;
      check_all("async_reset", 4'b0000, 1'b0, 4'b0000, 4'b0000);
      $display("async reset: grant=%b holding=%b miss8=%b miss2=%b", grant8, hold8, miss8, miss2);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      for (int k = 0; k < 2; k++) begin
         step(4'b0000);
         check_all($sformatf("post_reset_idle%0d", k), 4'b0000, 1'b0, 4'b0000, 4'b0000);
         $display("post reset idle %0d: grant=%b", k, grant8);
      end
      step(4'b1000);
      check_all("post_reset_req3", 4'b1000, 1'b0, 4'b0000, 4'b0000);
      $display("post reset req=1000: grant=%b", grant8);
      step(4'b0000);
      check_all("post_reset_cool", 4'b0000, 1'b0, 4'b0000, 4'b0000);
      $display("post reset cool: grant=%b", grant8);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
